saida_serial: RTL
=================

# saida_serial

Memory-mapped serial output stage for the nRisc processor, placed directly downstream of the data-memory write port. It captures `st` stores aimed at a single I/O address, buffers them in a small FIFO and sends each byte on `tx` as an 8N1 UART frame. Software can print strings (for example the "HELLO" table in data memory) without stalling the core.

## Interface
Parameters:
- `DIVISOR`, 16: clock cycles per serial bit; legal range 2–255.
- `ENDERECO_IO`, 8'h7F: data address that selects the output port.
- `PROFUNDIDADE`, 4: FIFO depth in bytes; must be a power of 2.

Ports:
- `Clock` in 1: single clock; every register in the block is on its rising edge.
- `Reset` in 1: asynchronous, active-low.
- `MemWrite` in 1: store strobe from the processor controller.
- `endereco` in 8: store address (the processor's `dado2`).
- `dadoEscrever` in 8: store data (the processor's `dado1`).
- `tx` out 1: serial line, idle high; registered.
- `vazio` out 1: FIFO count == 0.
- `cheio` out 1: FIFO count == `PROFUNDIDADE`.
- `ocupado` out 1: FSM is not in `OCIOSO`.
- `descartados` out 8: count of stores lost because the FIFO was full; saturates at 255.

## Operation
- **Capture:** a push is requested when `MemWrite` is high and `endereco` == `ENDERECO_IO`, sampled at a rising edge. Stores to any other address are ignored. This block never blocks memory writes.
- **Push acceptance:** a push is accepted if count < `PROFUNDIDADE`, or if a pop happens on the same edge.
- **Dropped push:** a push that is not accepted is dropped and `descartados` increments. At 255 the counter holds.
- **FSM states:** `OCIOSO`, `INICIO`, `DADOS`, `PARADA`.
- **Bit timing:** a bit counter runs 0..`DIVISOR`-1. A 3-bit index tracks the data bit.
- **`OCIOSO`:** `tx`=1. If the FIFO is not empty, pop the head into the shift register, go to `INICIO`, and drive `tx`=0 from that edge.
- **`INICIO`:** after `DIVISOR` cycles, go to `DADOS` and drive `tx`=shift[0].
- **`DADOS`:** each bit lasts `DIVISOR` cycles, sent LSB first. After bit 7, go to `PARADA` with `tx`=1.
- **`PARADA`:** lasts `DIVISOR` cycles. At its end:
  - if the FIFO is not empty, pop and go straight to `INICIO` (no idle gap);
  - otherwise go to `OCIOSO`.
- **Simultaneous push/pop:**
  - with the FIFO empty: the push is written and no pop occurs, because the pop decision uses the registered count;
  - with the FIFO full: both happen, count is unchanged and nothing is dropped.
- **FIFO pointers:** log2(`PROFUNDIDADE`) bits wide, wrap modulo depth. Count is log2(`PROFUNDIDADE`)+1 bits.

## Timing
- **Reset values:** asserting `Reset` low forces, immediately and asynchronously:
  - `tx`=1, `vazio`=1, `cheio`=0, `ocupado`=0, `descartados`=0;
  - FSM in `OCIOSO`, FIFO pointers and count at 0.
- **Reset mid-frame:** the frame is aborted and `tx` returns high at once. Buffered data is lost.
- **Latency:** a store accepted at edge k with the block idle produces the start-bit falling edge of `tx` at edge k+1.
- **Frame length:** exactly 10×`DIVISOR` cycles.
- **Back-to-back frames:** consecutive frames from a non-empty FIFO are contiguous; the next start bit follows the stop bit's last cycle.
- **Status flags:** `vazio` and `cheio` reflect the count after the most recent edge. The processor may write again in the same cycle that `cheio` falls.

## Structure
- **Shared package `nrisc_pkg`:**
  - FSM state enum (`OCIOSO`, `INICIO`, `DADOS`, `PARADA`);
  - default constants `DIVISOR_PADRAO`=16 and `ENDERECO_IO_PADRAO`=8'h7F, reused by the top-level and the bench.
- **Sub-module `fila_saida`:** the parameterised synchronous FIFO, with push/pop, data out, count, `vazio` and `cheio`.
- **Top level:** holds the capture decode, baud counter, shift register, FSM and drop counter.

## Test plan
All scenarios use `DIVISOR`=4.
- **Reset:** hold `Reset` low → `tx`=1, `vazio`=1, `cheio`=0, `ocupado`=0, `descartados`=0.
- **Single store:** store 8'h48 to 8'h7F → `tx` goes low at the next edge. Sampled every 4 cycles, `tx` reads 0, 0,0,0,1,0,0,1,0, 1. Total frame is 40 cycles, then `ocupado`=0 and `vazio`=1.
- **Non-I/O address:** store 8'h55 to 8'h05 with `MemWrite`=1 → `tx` stays 1 and `vazio` stays 1.
- **Burst overflow:** 6 consecutive-cycle stores 8'h41..8'h46 →
  - `cheio`=1 after the 5th store, and the 6th store is dropped (`descartados`=1);
  - frames carry 41, 42, 43, 44, 45 with no idle cycle between them.
- **Full plus pop:** with the FIFO full, store on the edge where `PARADA` ends → the pop occurs, the push is accepted, count stays 4 and `descartados` is unchanged.
- **Reset mid-frame:** pull `Reset` low during `DADOS` bit 3 → `tx`=1 without waiting for a clock edge and `vazio`=1. After release, no residual frame is sent.

Source files
------------

// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared types and default constants for the nRisc serial output stage
package nrisc_pkg;

    // Transmitter frame states
    typedef enum logic [1:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PARADA
    } estado_t;

    localparam int         DIVISOR_PADRAO     = 16;
    localparam logic [7:0] ENDERECO_IO_PADRAO = 8'h7F;

endpackage

// File: rtl/fila_saida.sv
// rtl/fila_saida.sv - parameterised synchronous FIFO holding bytes awaiting transmission
// Ports: clk, rst_n (async active-low); push/dado_in write side with aceito telling
// whether the write was taken; pop/dado_out read side (dado_out shows the head);
// contagem, vazio, cheio report occupancy after the most recent edge.
module fila_saida #(
    parameter int LARGURA      = 8,
    parameter int PROFUNDIDADE = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [LARGURA-1:0]            dado_in,
    input  logic                          pop,
    output logic [LARGURA-1:0]            dado_out,
    output logic                          aceito,
    output logic [$clog2(PROFUNDIDADE):0] contagem,
    output logic                          vazio,
    output logic                          cheio
);
    localparam int PW = $clog2(PROFUNDIDADE);
    localparam int CW = PW + 1;

    logic [LARGURA-1:0] mem [PROFUNDIDADE];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;

    assign vazio    = (contagem == '0);
    assign cheio    = (contagem == CW'(PROFUNDIDADE));
    // A pop on the same edge frees the slot, so a full FIFO still takes the write.
    assign aceito   = push && (!cheio || pop);
    assign dado_out = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (aceito) begin
            mem[wr_ptr] <= dado_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            contagem <= '0;
        end else begin
            if (aceito) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({aceito, pop})
                2'b10:   contagem <= contagem + CW'(1);
                2'b01:   contagem <= contagem - CW'(1);
                default: contagem <= contagem;
            endcase
        end
    end

endmodule

// File: rtl/saida_serial.sv
// rtl/saida_serial.sv - memory-mapped 8N1 serial output stage fed by processor stores
// Ports: Clock, Reset (async active-low); MemWrite/endereco/dadoEscrever store bus;
// tx serial line (idle high, registered); vazio/cheio FIFO flags; ocupado frame in
// progress; descartados saturating count of stores lost to a full FIFO.
module saida_serial
    import nrisc_pkg::*;
#(
    parameter int         DIVISOR      = DIVISOR_PADRAO,
    parameter logic [7:0] ENDERECO_IO  = ENDERECO_IO_PADRAO,
    parameter int         PROFUNDIDADE = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       MemWrite,
    input  logic [7:0] endereco,
    input  logic [7:0] dadoEscrever,
    output logic       tx,
    output logic       vazio,
    output logic       cheio,
    output logic       ocupado,
    output logic [7:0] descartados
);
    localparam logic [7:0] ULTIMO = 8'(DIVISOR - 1);

    estado_t estado, estado_prox;
    logic [7:0] cnt, cnt_prox;
    logic [2:0] indice, indice_prox;
    logic [7:0] shift, shift_prox;
    logic       tx_prox;
    logic       pop;
    logic       push_req;
    logic       aceito;
    logic [7:0] cabeca;
    logic [$clog2(PROFUNDIDADE):0] contagem;
    logic       tem_dado;

    assign push_req = MemWrite && (endereco == ENDERECO_IO);
    // Pop decisions look only at the registered count, so a byte pushed this
    // edge into an empty FIFO is not popped until the next one.
    assign tem_dado = (contagem != '0);
    assign ocupado  = (estado != OCIOSO);

    fila_saida #(
        .LARGURA      (8),
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fila (
        .clk      (Clock),
        .rst_n    (Reset),
        .push     (push_req),
        .dado_in  (dadoEscrever),
        .pop      (pop),
        .dado_out (cabeca),
        .aceito   (aceito),
        .contagem (contagem),
        .vazio    (vazio),
        .cheio    (cheio)
    );

    always_comb begin
        estado_prox = estado;
        cnt_prox    = cnt;
        indice_prox = indice;
        shift_prox  = shift;
        tx_prox     = tx;
        pop         = 1'b0;
        case (estado)
            OCIOSO: begin
                tx_prox = 1'b1;
                if (tem_dado) begin
                    pop         = 1'b1;
                    shift_prox  = cabeca;
                    cnt_prox    = '0;
                    tx_prox     = 1'b0;
                    estado_prox = INICIO;
                end
            end
            INICIO: begin
                if (cnt == ULTIMO) begin
                    cnt_prox    = '0;
                    indice_prox = '0;
                    tx_prox     = shift[0];
                    estado_prox = DADOS;
                end else begin
                    cnt_prox = cnt + 8'd1;
                end
            end
            DADOS: begin
                if (cnt == ULTIMO) begin
                    cnt_prox = '0;
                    if (indice == 3'd7) begin
                        tx_prox     = 1'b1;
                        estado_prox = PARADA;
                    end else begin
                        indice_prox = indice + 3'd1;
                        shift_prox  = {1'b0, shift[7:1]};
                        tx_prox     = shift[1];
                    end
                end else begin
                    cnt_prox = cnt + 8'd1;
                end
            end
            PARADA: begin
                if (cnt == ULTIMO) begin
                    cnt_prox = '0;
                    // Chain straight into the next start bit to keep frames contiguous.
                    if (tem_dado) begin
                        pop         = 1'b1;
                        shift_prox  = cabeca;
                        tx_prox     = 1'b0;
                        estado_prox = INICIO;
                    end else begin
                        tx_prox     = 1'b1;
                        estado_prox = OCIOSO;
                    end
                end else begin
                    cnt_prox = cnt + 8'd1;
                end
            end
            default: begin
                tx_prox     = 1'b1;
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            estado      <= OCIOSO;
            cnt         <= '0;
            indice      <= '0;
            shift       <= '0;
            tx          <= 1'b1;
            descartados <= '0;
        end else begin
            estado <= estado_prox;
            cnt    <= cnt_prox;
            indice <= indice_prox;
            shift  <= shift_prox;
            tx     <= tx_prox;
            if (push_req && !aceito && (descartados != 8'hFF)) begin
                descartados <= descartados + 8'd1;
            end
        end
    end

endmodule
